// File: rtl/wb_write_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_write_queue : 4-entry register-file writeback queue with hazard        |
// |                  lookup; data forwarding enabled by macro WBQ_FORWARD_EN  |
// | Revision       : 1.0                                                      |
// +--------------------------------------------------------------------------+
module wb_write_queue (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_regsel,
   input  logic [15:0] in_data,
   input  logic        stall_wb,
   output logic        write,
   output logic [2:0]  writeregsel,
   output logic [15:0] writedata,
   input  logic [2:0]  chk1regsel,
   input  logic [2:0]  chk2regsel,
   output logic        hit1,
   output logic        hit2,
   output logic [15:0] hitdata1,
   output logic [15:0] hitdata2,
   output logic [2:0]  count,
   output logic        err
);

   localparam int         DEPTH  = 4;
   localparam logic [2:0] C_FULL = 3'd4;

   logic [1:0]  head_q, head_d;
   logic [1:0]  tail_q, tail_d;
   logic [2:0]  count_q, count_d;
   logic        err_q, err_d;
   logic [2:0]  regsel_q [DEPTH];
   logic [2:0]  regsel_d [DEPTH];
   logic [15:0] data_q [DEPTH];
   logic [15:0] data_d [DEPTH];
   logic        w_empty;
   logic        w_enq;

   assign w_empty     = (count_q == 3'd0);
   assign in_ready    = (count_q != C_FULL);
   assign w_enq       = in_valid & in_ready;
   assign write       = !w_empty & !stall_wb;
   assign writeregsel = w_empty ? 3'd0  : regsel_q[head_q];
   assign writedata   = w_empty ? 16'd0 : data_q[head_q];
   assign count       = count_q;
   assign err         = err_q;

   always_comb begin
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      regsel_d = regsel_q;
      data_d   = data_q;
      err_d    = in_valid & !in_ready;
      if (w_enq) begin
         regsel_d[tail_q] = in_regsel;
         data_d[tail_q]   = in_data;
         tail_d           = tail_q + 2'd1;
      end
      if (write) begin
         head_d = head_q + 2'd1;
      end
      case ({w_enq, write})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase
   end

   // Scan oldest to youngest so the youngest matching entry wins.
   always_comb begin : p_hits
      logic [1:0] idx;
      hit1     = 1'b0;
      hit2     = 1'b0;
      hitdata1 = 16'd0;
      hitdata2 = 16'd0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + 2'(i);
         if (3'(i) < count_q) begin
            if (regsel_q[idx] == chk1regsel) begin
               hit1 = 1'b1;
`ifdef WBQ_FORWARD_EN
               hitdata1 = data_q[idx];
`endif
            end
            if (regsel_q[idx] == chk2regsel) begin
               hit2 = 1'b1;
`ifdef WBQ_FORWARD_EN
               hitdata2 = data_q[idx];
`endif
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= 2'd0;
         tail_q  <= 2'd0;
         count_q <= 3'd0;
         err_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   // Storage is only visible through occupied slots, so it carries no reset.
   always_ff @(posedge clk) begin
      regsel_q <= regsel_d;
      data_q   <= data_d;
   end

endmodule
`default_nettype wire

// File: tb/tb_wb_write_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_write_queue : randomized and directed bench for wb_write_queue      |
// | Revision          : 1.0                                                  |
// +--------------------------------------------------------------------------+
module tb_wb_write_queue;

   typedef struct {
      logic [2:0]  rs;
      logic [15:0] d;
   } entry_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_regsel;
   logic [15:0] in_data;
   logic        stall_wb;
   logic        write;
   logic [2:0]  writeregsel;
   logic [15:0] writedata;
   logic [2:0]  chk1regsel;
   logic [2:0]  chk2regsel;
   logic        hit1;
   logic        hit2;
   logic [15:0] hitdata1;
   logic [15:0] hitdata2;
   logic [2:0]  count;
   logic        err;

   entry_t q[$];
   logic   err_exp;
   int     checks;
   int     failures;

   wb_write_queue dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_regsel   (in_regsel),
      .in_data     (in_data),
      .stall_wb    (stall_wb),
      .write       (write),
      .writeregsel (writeregsel),
      .writedata   (writedata),
      .chk1regsel  (chk1regsel),
      .chk2regsel  (chk2regsel),
      .hit1        (hit1),
      .hit2        (hit2),
      .hitdata1    (hitdata1),
      .hitdata2    (hitdata2),
      .count       (count),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference view: the queue holds pending writes oldest-first.
   task automatic compare_all(input string tag);
      logic [2:0]  ers;
      logic [15:0] ed;
      logic        h1, h2;
      logic [15:0] hd1, hd2;
      ers = 3'd0;
      ed  = 16'd0;
      if (q.size() > 0) begin
         ers = q[0].rs;
         ed  = q[0].d;
      end
      h1 = 1'b0; hd1 = 16'd0;
      h2 = 1'b0; hd2 = 16'd0;
      for (int k = q.size() - 1; k >= 0; k--) begin
         if (!h1 && q[k].rs == chk1regsel) begin h1 = 1'b1; hd1 = q[k].d; end
         if (!h2 && q[k].rs == chk2regsel) begin h2 = 1'b1; hd2 = q[k].d; end
      end
`ifndef WBQ_FORWARD_EN
      hd1 = 16'd0;
      hd2 = 16'd0;
`endif
      check({tag, ".count"},       32'(count),       32'(q.size()));
      check({tag, ".in_ready"},    32'(in_ready),    32'(q.size() != 4));
      check({tag, ".write"},       32'(write),       32'(q.size() != 0 && !stall_wb));
      check({tag, ".writeregsel"}, 32'(writeregsel), 32'(ers));
      check({tag, ".writedata"},   32'(writedata),   32'(ed));
      check({tag, ".err"},         32'(err),         32'(err_exp));
      check({tag, ".hit1"},        32'(hit1),        32'(h1));
      check({tag, ".hitdata1"},    32'(hitdata1),    32'(hd1));
      check({tag, ".hit2"},        32'(hit2),        32'(h2));
      check({tag, ".hitdata2"},    32'(hitdata2),    32'(hd2));
   endtask

   // One cycle: drive, compare before the edge, advance the model after it.
   task automatic step(input logic v, input logic [2:0] rs, input logic [15:0] d,
                       input logic st, input logic [2:0] c1, input logic [2:0] c2,
                       input string tag);
      int     sz;
      logic   do_pop, do_enq, nerr;
      entry_t e;
      in_valid   = v;
      in_regsel  = rs;
      in_data    = d;
      stall_wb   = st;
      chk1regsel = c1;
      chk2regsel = c2;
      #1;
      compare_all(tag);
      sz     = q.size();
      do_pop = (sz != 0) && !st;
      do_enq = v && (sz != 4);
      nerr   = v && (sz == 4);
      e.rs   = rs;
      e.d    = d;
      @(posedge clk);
      if (do_pop) void'(q.pop_front());
      if (do_enq) q.push_back(e);
      err_exp = nerr;
      #1;
   endtask

   task automatic idle(input logic st, input string tag);
      step(1'b0, 3'd0, 16'd0, st, 3'd0, 3'd0, tag);
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      err_exp    = 1'b0;
      rst        = 1'b0;
      in_valid   = 1'b0;
      in_regsel  = 3'd0;
      in_data    = 16'd0;
      stall_wb   = 1'b0;
      chk1regsel = 3'd0;
      chk2regsel = 3'd0;
      #12;
      compare_all("reset");
      check("reset.in_ready", 32'(in_ready), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Single write with one cycle latency.
      step(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 3'd0, "r030.enq");
      check("r030.write",       32'(write),       32'd1);
      check("r030.writeregsel", 32'(writeregsel), 32'd3);
      check("r030.writedata",   32'(writedata),   32'h1234);
      idle(1'b0, "r030.pop");
      check("r030.count_after", 32'(count), 32'd0);

      // Overflow under stall, then drain in order.
      for (int i = 0; i < 5; i++)
         step(1'b1, 3'(i + 1), 16'(16'hA000 + i), 1'b1, 3'd0, 3'd0, "r031.fill");
      check("r031.count_full", 32'(count),    32'd4);
      check("r031.in_ready",   32'(in_ready), 32'd0);
      check("r031.err",        32'(err),      32'd1);
      idle(1'b1, "r031.hold");
      check("r031.err_clear", 32'(err), 32'd0);
      for (int i = 0; i < 4; i++) begin
         stall_wb = 1'b0;
         #1;
         check("r031.drain_write", 32'(write),     32'd1);
         check("r031.drain_data",  32'(writedata), 32'(16'hA000 + i));
         idle(1'b0, "r031.drain");
      end
      check("r031.empty", 32'(count), 32'd0);

      // Youngest matching entry forwards.
      step(1'b1, 3'd2, 16'h0001, 1'b1, 3'd2, 3'd0, "r032.enq1");
      step(1'b1, 3'd2, 16'h0002, 1'b1, 3'd2, 3'd0, "r032.enq2");
      step(1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd7, "r032.look");
      check("r032.hit1", 32'(hit1), 32'd1);
`ifdef WBQ_FORWARD_EN
      check("r032.hitdata1", 32'(hitdata1), 32'h0002);
`else
      check("r032.hitdata1", 32'(hitdata1), 32'h0000);
`endif
      check("r035.hit2",     32'(hit2),     32'd0);
      check("r035.hitdata2", 32'(hitdata2), 32'd0);
      idle(1'b0, "r032.drain");
      idle(1'b0, "r032.drain");

      // Simultaneous enqueue and pop across pointer wrap.
      step(1'b1, 3'd4, 16'hB000, 1'b1, 3'd0, 3'd0, "r033.pre");
      step(1'b1, 3'd5, 16'hB001, 1'b1, 3'd0, 3'd0, "r033.pre");
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 3'(i), 16'(16'hB100 + i), 1'b0, 3'd0, 3'd0, "r033.flow");
         check("r033.count", 32'(count), 32'd2);
      end
      idle(1'b0, "r033.drain");
      idle(1'b0, "r033.drain");

      // Reset mid-operation discards pending entries.
      for (int i = 0; i < 3; i++)
         step(1'b1, 3'(i), 16'(16'hC000 + i), 1'b1, 3'd0, 3'd0, "r034.fill");
      in_valid = 1'b0;
      stall_wb = 1'b0;
      #3;
      rst = 1'b0;
      #1;
      q.delete();
      err_exp = 1'b0;
      check("r034.write", 32'(write), 32'd0);
      check("r034.count", 32'(count), 32'd0);
      compare_all("r034.inreset");
      #2;
      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         idle(1'b0, "r034.after");
         check("r034.nowrite", 32'(write), 32'd0);
      end

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
              3'($urandom_range(0, 7)), 16'($urandom),
              ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0,
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
